// File: rtl/pulse_extender.sv
// Stretches each rising edge of entrada into a HOLD_CYCLES-wide pulse on saida,
// spaced by at least GAP_CYCLES low cycles, queueing overlapping events in a saturating counter.
module pulse_extender #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             resetPC,
  input  logic             entrada,
  output logic             saida,
  output logic             ocupado,
  output logic [CNT_W-1:0] pendentes,
  output logic             estouro
);

  localparam int unsigned MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0]    HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]    GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [CNT_W-1:0] pend_nxt;
  logic             ovf_nxt;
  logic             prev;
  logic             evt, done, gap_end, inc, dec;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      timer     <= '0;
      pendentes <= '0;
      estouro   <= 1'b0;
      saida     <= 1'b0;
      prev      <= 1'b0;
    end else if (resetPC) begin
      state     <= IDLE;
      timer     <= '0;
      pendentes <= '0;
      estouro   <= 1'b0;
      saida     <= 1'b0;
      prev      <= entrada;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      pendentes <= pend_nxt;
      estouro   <= ovf_nxt;
      saida     <= (state_nxt == HOLD);
      prev      <= entrada;
    end
  end

  // At GAP end a same-edge event either cancels the decrement or starts HOLD directly,
  // so pendentes is unchanged whenever an event lands on that edge.
  always_comb begin
    evt     = entrada & ~prev;
    done    = (timer == '0);
    gap_end = (state == GAP) && done;
    inc     = evt && ((state == HOLD) || ((state == GAP) && !done));
    dec     = gap_end && (pendentes != '0) && !evt;

    state_nxt = state;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        if (evt) begin
          state_nxt = HOLD;
          timer_nxt = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (done) begin
          state_nxt = GAP;
          timer_nxt = GAP_LOAD;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      GAP: begin
        if (done) begin
          if ((pendentes != '0) || evt) begin
            state_nxt = HOLD;
            timer_nxt = HOLD_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase

    pend_nxt = pendentes;
    ovf_nxt  = estouro;
    if (inc) begin
      if (pendentes == PEND_MAX) ovf_nxt  = 1'b1;
      else                       pend_nxt = pendentes + CNT_W'(1);
    end else if (dec) begin
      pend_nxt = pendentes - CNT_W'(1);
    end
  end

  always_comb begin
    ocupado = (state != IDLE);
  end

endmodule

// File: tb/tb_pulse_extender.sv
// Directed bench for pulse_extender at default parameters (HOLD 4, GAP 2, CNT_W 4).
module tb_pulse_extender;

  logic       clock = 1'b0;
  logic       reset, resetPC, entrada;
  logic       saida, ocupado, estouro;
  logic [3:0] pendentes;

  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   highs  = 0;
  int   p0     = 0;
  logic last_s = 1'b0;

  always #5 clock = ~clock;

  pulse_extender #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .CNT_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .resetPC   (resetPC),
    .entrada   (entrada),
    .saida     (saida),
    .ocupado   (ocupado),
    .pendentes (pendentes),
    .estouro   (estouro)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later; tracks saida pulses.
  task automatic tick();
    @(posedge clock);
    #1;
    if (saida && !last_s) pulses++;
    if (saida) highs++;
    last_s = saida;
  endtask

  initial begin
    reset   = 1'b1;
    resetPC = 1'b0;
    entrada = 1'b0;
    #2 reset = 1'b0;
    #10;
    chk("rst_saida", saida, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_pend", pendentes, 0);
    chk("rst_estouro", estouro, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    tick(); tick();

    // single one-cycle event
    entrada = 1'b1;
    tick();
    entrada = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("single_saida", saida, (i < 4));
      chk("single_ocupado", ocupado, (i < 6));
      chk("single_pend", pendentes, 0);
      if (i < 6) tick();
    end

    // held-high input yields one pulse
    pulses = 0; highs = 0;
    entrada = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("held_pend", pendentes, 0);
    end
    entrada = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("held_pulses", pulses, 1);
    chk("held_highs", highs, 4);
    chk("held_idle", ocupado, 0);

    // three events two cycles apart
    pulses = 0; highs = 0;
    for (int i = 0; i < 20; i++) begin
      entrada = ((i % 2) == 0) && (i <= 4);
      tick();
      chk("three_saida", saida, ((i % 6) < 4) && (i < 18));
      chk("three_pend", pendentes,
          (i < 2) ? 0 : (i < 4) ? 1 : (i < 6) ? 2 : (i < 12) ? 1 : 0);
    end
    entrada = 1'b0;
    chk("three_pulses", pulses, 3);
    chk("three_highs", highs, 12);
    chk("three_idle", ocupado, 0);
    chk("three_estouro", estouro, 0);

    // event exactly on the GAP-end edge with nothing pending
    for (int i = 0; i < 13; i++) begin
      entrada = (i == 0) || (i == 6);
      tick();
      chk("gapend_saida", saida, ((i % 6) < 4) && (i < 12));
      chk("gapend_pend", pendentes, 0);
    end
    entrada = 1'b0;
    tick();
    chk("gapend_idle", ocupado, 0);

    // saturation: 30 events every 2 cycles, 5 lost
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      entrada = 1'b1;
      tick();
      if (k == 22) begin
        chk("sat_pend15", pendentes, 15);
        chk("sat_noovf", estouro, 0);
      end
      if (k == 23) begin
        chk("sat_ovf", estouro, 1);
        chk("sat_hold15", pendentes, 15);
      end
      entrada = 1'b0;
      tick();
    end
    chk("sat_end_pend", pendentes, 15);
    for (int c = 0; c < 200 && ocupado; c++) tick();
    chk("sat_drained", ocupado, 0);
    chk("sat_pulses", pulses, 25);
    chk("sat_pend0", pendentes, 0);
    chk("sat_sticky", estouro, 1);

    // synchronous clear mid-HOLD with pendentes=3, estouro=1
    for (int k = 0; k < 30; k++) begin
      entrada = 1'b1;
      tick();
      entrada = 1'b0;
      tick();
    end
    for (int c = 0; c < 200 && !((pendentes == 4'd3) && saida); c++) tick();
    chk("clr_pre_pend", pendentes, 3);
    chk("clr_pre_saida", saida, 1);
    chk("clr_pre_ovf", estouro, 1);
    resetPC = 1'b1;
    entrada = 1'b1;
    tick();
    resetPC = 1'b0;
    chk("clr_saida", saida, 0);
    chk("clr_ocupado", ocupado, 0);
    chk("clr_pend", pendentes, 0);
    chk("clr_estouro", estouro, 0);
    p0 = pulses;
    for (int i = 0; i < 5; i++) tick();
    entrada = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("clr_nopulse", pulses, p0);
    chk("clr_idle", ocupado, 0);

    // asynchronous reset mid-HOLD, entrada high on release
    entrada = 1'b1;
    tick();
    entrada = 1'b0;
    tick(); tick();
    chk("arst_pre_saida", saida, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_saida", saida, 0);
    chk("arst_ocupado", ocupado, 0);
    chk("arst_pend", pendentes, 0);
    chk("arst_estouro", estouro, 0);
    last_s  = saida;
    entrada = 1'b1;
    #2 reset = 1'b1;
    p0 = pulses;
    tick();
    chk("arst_resume_saida", saida, 1);
    chk("arst_resume_ocupado", ocupado, 1);
    for (int i = 0; i < 10; i++) tick();
    chk("arst_one_pulse", pulses, p0 + 1);
    chk("arst_idle", ocupado, 0);
    entrada = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_extender.md
PULSE_EXTENDER -- requirements
Module: pulse_extender

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, meaning clock cycles saida stays high per event; legal range >= 1.
REQ-002 Parameter GAP_CYCLES, default 2, meaning minimum low cycles between consecutive saida pulses; legal range >= 1.
REQ-003 Parameter CNT_W, default 4, meaning width of the pending-event counter; saturation value is 2^CNT_W-1.
REQ-004 Port clock  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port resetPC  input  1  synchronous, active-high clear, sampled on the rising edge of clock.
REQ-007 Port entrada  input  1  event input; each 0->1 transition is one event.
REQ-008 Port saida  output  1  stretched pulse output, registered.
REQ-009 Port ocupado  output  1  high whenever the state machine is not IDLE.
REQ-010 Port pendentes  output  CNT_W  count of accepted events not yet started on saida.
REQ-011 Port estouro  output  1  sticky flag: an event was lost to counter saturation.

Function
REQ-012 The block SHALL register entrada every cycle into prev; an event SHALL be detected when entrada=1 and prev=0 at a rising clock edge.
REQ-013 The block SHALL implement states IDLE, HOLD, GAP with a down-counter timer sized for max(HOLD_CYCLES, GAP_CYCLES).
REQ-014 IDLE + event -> HOLD on that same edge: saida=1, timer loaded, pendentes unchanged; saida is therefore high in the cycle after the detecting edge (latency 1).
REQ-015 HOLD SHALL last exactly HOLD_CYCLES cycles with saida=1, then -> GAP with saida=0.
REQ-016 GAP SHALL last exactly GAP_CYCLES cycles with saida=0; at its end: pendentes>0 -> HOLD and pendentes decrements; pendentes=0 -> IDLE.
REQ-017 An event detected in HOLD or GAP SHALL increment pendentes by 1.
REQ-018 Event coinciding with the GAP-end decrement SHALL leave pendentes unchanged (net zero) and start HOLD.
REQ-019 Event while pendentes=2^CNT_W-1 with no same-cycle decrement SHALL leave pendentes unchanged and set estouro=1.
REQ-020 pendentes SHALL never wrap; it never exceeds 2^CNT_W-1 and never goes below 0.
REQ-021 estouro SHALL remain 1 until reset or resetPC.
REQ-022 A held-high entrada SHALL produce exactly one event regardless of duration.
REQ-023 ocupado SHALL be 1 in HOLD and GAP, 0 in IDLE.

Reset
REQ-024 reset=0 SHALL immediately, without a clock edge, force state=IDLE, saida=0, ocupado=0, pendentes=0, estouro=0, timer=0, prev=0.
REQ-025 resetPC=1 at a rising edge SHALL force the same values as REQ-024 except prev, which SHALL load entrada; an event on that edge SHALL be discarded.
REQ-026 reset SHALL take priority over resetPC; resetPC SHALL take priority over event detection and all state transitions.
REQ-027 After reset deasserts with entrada already high, no event SHALL be detected until entrada returns to 0 and rises again... except that prev=0 after async reset, so the first edge sampling entrada=1 SHALL count as one event.

Verification
REQ-028 Defaults; single 1-cycle entrada pulse detected at edge n -> saida=1 in cycles n+1..n+4, 0 from n+5, ocupado falls after cycle n+6, pendentes=0 throughout.
REQ-029 entrada held high 20 cycles -> exactly one 4-cycle saida pulse, pendentes stays 0.
REQ-030 Three events 2 cycles apart starting in IDLE -> three pulses each 4 high / 2 low, pendentes peaks at 2 and drains to 0, estouro=0.
REQ-031 Events every 2 cycles for 60 cycles -> pendentes reaches 15 and holds, estouro rises on the first event seen at 15 without decrement, total pulses = events accepted.
REQ-032 resetPC pulsed mid-HOLD with pendentes=3, estouro=1 -> next cycle saida=0, ocupado=0, pendentes=0, estouro=0; no further pulses.
REQ-033 reset driven low mid-HOLD between clock edges -> saida and all outputs 0 before the next clock edge; normal operation resumes after release.
